// File: rtl/serial_min2_finder.sv
// Serial two-minimum finder for LDPC check-node messages: streams one signed
// message per beat and reports the two smallest magnitudes, min index, sign parity and degree.
module serial_min2_finder #(
    parameter int BITS    = 8,
    parameter int DEG_MAX = 32,
    localparam int IW     = $clog2(DEG_MAX)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-2:0] out_min1,
    output logic [BITS-2:0] out_min2,
    output logic [IW-1:0]   out_idx,
    output logic            out_sign,
    output logic [IW:0]     out_deg
);

    // Handshakes: a beat moves on a rising edge with in_valid & in_ready, a result
    // moves with out_valid & out_ready; valid never depends on the matching ready.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [BITS-2:0] MAG_MAX  = {(BITS-1){1'b1}};
    localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [IW:0]     DEG_FULL = (IW+1)'(DEG_MAX);

    logic [1:0]      state;
    logic [BITS-2:0] min1_q;
    logic [BITS-2:0] min2_q;
    logic [IW-1:0]   idx_q;
    logic            sign_q;
    logic [IW:0]     cnt_q;

    logic            in_sign;
    logic [BITS-1:0] neg_data;
    logic [BITS-2:0] mag;
    logic [IW:0]     cnt_next;
    logic            frame_end;

    assign in_ready  = (state != S_HOLD);
    assign out_valid = (state == S_HOLD);
    assign out_min1  = min1_q;
    assign out_min2  = min2_q;
    assign out_idx   = idx_q;
    assign out_sign  = sign_q;
    assign out_deg   = cnt_q;

    // The most negative code has no positive twin, so it saturates to MAG_MAX.
    always_comb begin
        in_sign  = in_data[BITS-1];
        neg_data = ~in_data + 1'b1;
        if (in_data == MOST_NEG) begin
            mag = MAG_MAX;
        end else if (in_sign) begin
            mag = neg_data[BITS-2:0];
        end else begin
            mag = in_data[BITS-2:0];
        end
    end

    // Count after this beat; reaching DEG_MAX closes the frame so cnt never wraps.
    always_comb begin
        cnt_next  = (state == S_IDLE) ? (IW+1)'(1) : cnt_q + 1'b1;
        frame_end = in_last || (cnt_next == DEG_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            min1_q <= MAG_MAX;
            min2_q <= MAG_MAX;
            idx_q  <= '0;
            sign_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        min1_q <= mag;
                        min2_q <= MAG_MAX;
                        idx_q  <= '0;
                        sign_q <= in_sign;
                        cnt_q  <= cnt_next;
                        state  <= frame_end ? S_HOLD : S_ACC;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        // Strict less-than: an equal later value only competes for min2.
                        if (mag < min1_q) begin
                            min2_q <= min1_q;
                            min1_q <= mag;
                            idx_q  <= cnt_q[IW-1:0];
                        end else if (mag < min2_q) begin
                            min2_q <= mag;
                        end
                        sign_q <= sign_q ^ in_sign;
                        cnt_q  <= cnt_next;
                        if (frame_end) begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_min2_finder.sv
// Bench for serial_min2_finder (BITS=8, DEG_MAX=4): directed frames plus random
// frames, results matched by a scoreboard queue against a reference model.
module tb_serial_min2_finder;

    localparam int BITS = 8;
    localparam int DEG  = 4;
    localparam int IW   = $clog2(DEG);

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-2:0] out_min1;
    logic [BITS-2:0] out_min2;
    logic [IW-1:0]   out_idx;
    logic            out_sign;
    logic [IW:0]     out_deg;

    typedef struct packed {
        logic [6:0] min1;
        logic [6:0] min2;
        logic [1:0] idx;
        logic       sign;
        logic [2:0] deg;
    } res_t;

    res_t       exp_q[$];
    logic [7:0] fr[0:3];
    int         n_vec;
    int         n_err;
    int         sink_mode;
    bit         hold_chk;
    res_t       snap;

    serial_min2_finder #(.BITS(BITS), .DEG_MAX(DEG)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min1(out_min1), .out_min2(out_min2), .out_idx(out_idx),
        .out_sign(out_sign), .out_deg(out_deg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t mk(input int a, input int b, input int i, input int s, input int d);
        res_t r;
        r.min1 = 7'(a);
        r.min2 = 7'(b);
        r.idx  = 2'(i);
        r.sign = 1'(s);
        r.deg  = 3'(d);
        return r;
    endfunction

    // Reference: smallest magnitude (earliest on ties) and smallest of the rest.
    function automatic res_t model(input int n);
        int m[4];
        int best;
        int second;
        int s;
        for (int i = 0; i < n; i++) begin
            if (fr[i] == 8'h80) m[i] = 127;
            else if (fr[i][7])  m[i] = 256 - int'(fr[i]);
            else                m[i] = int'(fr[i]);
        end
        best = 0;
        for (int i = 1; i < n; i++) if (m[i] < m[best]) best = i;
        second = 127;
        for (int i = 0; i < n; i++) if (i != best && m[i] < second) second = m[i];
        s = 0;
        for (int i = 0; i < n; i++) s = s ^ int'(fr[i][7]);
        return mk(m[best], second, best, s, n);
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_min1", out_min1, 127);
        chk("rst_min2", out_min2, 127);
        chk("rst_idx", out_idx, 0);
        chk("rst_sign", out_sign, 0);
        chk("rst_deg", out_deg, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [7:0] d, input logic last);
        bit ok;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit use_last);
        for (int i = 0; i < n; i++) drive_beat(fr[i], use_last && (i == n - 1));
        if (use_last || n == DEG) begin
            @(negedge clk);
            chk("latency_out_valid", out_valid, 1);
        end
    endtask

    // ---------------- sink ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 0;
        end else begin
            res_t cur;
            res_t e;
            cur = mk(int'(out_min1), int'(out_min2), int'(out_idx), int'(out_sign), int'(out_deg));
            chk("in_ready_vs_out_valid", in_ready, !out_valid);
            if (hold_chk) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_stable", cur, snap);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("min1", cur.min1, e.min1);
                    chk("min2", cur.min2, e.min2);
                    chk("idx", cur.idx, e.idx);
                    chk("sign", cur.sign, e.sign);
                    chk("deg", cur.deg, e.deg);
                end
                hold_chk = 0;
            end else if (out_valid) begin
                hold_chk = 1;
                snap     = cur;
            end else begin
                hold_chk = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec     = 0;
        n_err     = 0;
        sink_mode = 1;
        hold_chk  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        do_reset();
        sink_mode = 0;

        // V1
        fr = '{8'd5, 8'hFD, 8'd7, 8'hFE};
        exp_q.push_back(mk(2, 3, 3, 0, 4));
        send_frame(4, 1);
        // V2: -128 saturates, tie keeps earliest index
        fr = '{8'h80, 8'd4, 8'd4, 8'd0};
        exp_q.push_back(mk(4, 4, 1, 1, 3));
        send_frame(3, 1);
        // V3: single beat
        fr = '{8'hFA, 8'd0, 8'd0, 8'd0};
        exp_q.push_back(mk(6, 127, 0, 1, 1));
        send_frame(1, 1);

        // V4: forced termination, fifth beat blocked
        sink_mode = 1;
        fr = '{8'd9, 8'd8, 8'd1, 8'd3};
        exp_q.push_back(mk(1, 3, 2, 0, 4));
        send_frame(4, 0);
        in_valid = 1'b1;
        in_data  = 8'd5;
        repeat (3) begin
            @(negedge clk);
            chk("v4_fifth_blocked", in_ready, 0);
        end
        in_valid = 1'b0;

        // V5: long stall then a single out_ready pulse
        @(negedge clk);
        sink_mode = 2;
        @(negedge clk);
        sink_mode = 1;
        fr = '{8'd10, 8'hEC, 8'd3, 8'd0};
        exp_q.push_back(mk(3, 10, 2, 1, 3));
        send_frame(3, 1);
        repeat (10) begin
            @(negedge clk);
            chk("v5_out_valid", out_valid, 1);
            chk("v5_in_ready", in_ready, 0);
        end
        sink_mode = 2;
        @(negedge clk);
        sink_mode = 1;
        @(negedge clk);
        chk("v5_in_ready_after", in_ready, 1);
        chk("v5_out_valid_after", out_valid, 0);

        // Reset while a result is held
        fr = '{8'd4, 8'd5, 8'd0, 8'd0};
        exp_q.push_back(mk(4, 5, 0, 0, 2));
        send_frame(2, 1);
        do_reset();
        sink_mode = 0;

        // V6: reset mid-frame, then a clean frame
        fr = '{8'd50, 8'd60, 8'd0, 8'd0};
        send_frame(2, 0);
        do_reset();
        fr = '{8'd2, 8'd1, 8'd0, 8'd0};
        exp_q.push_back(mk(1, 2, 1, 0, 2));
        send_frame(2, 1);

        // Random frames
        for (int f = 0; f < 60; f++) begin
            int  n;
            bit  ul;
            n  = $urandom_range(1, DEG);
            ul = (n < DEG) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < DEG; i++) begin
                case ($urandom_range(0, 3))
                    0:       fr[i] = 8'h80;
                    1:       fr[i] = 8'($urandom_range(0, 3));
                    2:       fr[i] = 8'(256 - $urandom_range(1, 3));
                    default: fr[i] = 8'($urandom_range(0, 255));
                endcase
            end
            exp_q.push_back(model(n));
            send_frame(n, ul);
        end

        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
